// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling
// and saturating stall/flush event counters.
module id_ex_hazard_stage #(
    parameter int XLEN = 64,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_funct,
    input  logic            id_branch,
    input  logic            id_memread,
    input  logic            id_memtoreg,
    input  logic            id_memwrite,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic [1:0]      id_aluop,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic [1:0]      ex_aluop,
    output logic            stall,
    output logic            pc_write,
    output logic            if_id_write,
    output logic [CNTW-1:0] stall_count,
    output logic [CNTW-1:0] flush_count
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic hazard;
    logic rs2_used;
    logic bubble;

    // rs2 only matters when it feeds the ALU or supplies store data.
    always_comb begin
        rs2_used = ~id_alusrc | id_memwrite;
        hazard   = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                   ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & rs2_used));
        stall    = hazard & ~flush;
        bubble   = flush | stall | ~id_valid;
    end

    assign pc_write    = ~stall;
    assign if_id_write = ~stall;

    // Data and index fields always follow decode; only control is squashed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_funct    <= '0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluop    <= 2'b00;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_funct    <= '0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluop    <= 2'b00;
        end else begin
            ex_valid    <= 1'b1;
            ex_funct    <= id_funct;
            ex_branch   <= id_branch;
            ex_memread  <= id_memread;
            ex_memtoreg <= id_memtoreg;
            ex_memwrite <= id_memwrite;
            ex_alusrc   <= id_alusrc;
            ex_regwrite <= id_regwrite;
            ex_aluop    <= id_aluop;
        end
    end

    // A flushed slot only counts if it actually killed a real instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != CNT_MAX)
                stall_count <= stall_count + 1'b1;
            if (flush && id_valid && flush_count != CNT_MAX)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Randomized and directed bench for id_ex_hazard_stage against an
// instruction-level reference model of the ID/EX slot.
module tb_id_ex_hazard_stage;

    localparam int XLEN    = 64;
    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
        logic            branch;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            alusrc;
        logic            regwrite;
        logic [1:0]      aluop;
    } instr_t;

    logic clk;
    logic reset;
    logic flush;
    instr_t id_cur;
    instr_t ex_obs;

    logic            id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [3:0]      id_funct;
    logic [1:0]      id_aluop;

    logic            ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_funct;
    logic [1:0]      ex_aluop;
    logic            stall, pc_write, if_id_write;
    logic [CNTW-1:0] stall_count, flush_count;

    assign {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct,
            id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_aluop} = id_cur;
    assign ex_obs = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
                     ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop};

    id_ex_hazard_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
        .ex_aluop(ex_aluop), .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: what instruction occupies EX, plus event tallies.
    instr_t m_ex;
    int     m_stalls;
    int     m_flushes;

    task automatic checkOutput(input string tag, input logic [319:0] actual, input logic [319:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic load_use(input instr_t ex, input instr_t id);
        logic reads_rs2;
        reads_rs2 = !id.alusrc || id.memwrite;
        return ex.valid && ex.memread && ex.rd != 0 && id.valid &&
               (ex.rd == id.rs1 || (ex.rd == id.rs2 && reads_rs2));
    endfunction

    function automatic logic [7:0] ctrl_of(input instr_t x);
        return {x.valid, x.branch, x.memread, x.memtoreg, x.memwrite, x.regwrite, x.aluop};
    endfunction

    function automatic logic [275:0] data_of(input instr_t x);
        return {x.pc, x.rs1_data, x.rs2_data, x.imm, x.rs1, x.rs2, x.rd, x.funct, x.alusrc};
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.valid    = ($urandom_range(0, 7) != 0);
        r.pc       = {$urandom, $urandom};
        r.rs1_data = {$urandom, $urandom};
        r.rs2_data = {$urandom, $urandom};
        r.imm      = {$urandom, $urandom};
        r.rs1      = 5'($urandom_range(0, 7));
        r.rs2      = 5'($urandom_range(0, 7));
        r.rd       = 5'($urandom_range(0, 7));
        r.funct    = 4'($urandom);
        r.branch   = 1'($urandom);
        r.memread  = 1'($urandom);
        r.memtoreg = 1'($urandom);
        r.memwrite = 1'($urandom);
        r.alusrc   = 1'($urandom);
        r.regwrite = 1'($urandom);
        r.aluop    = 2'($urandom);
        return r;
    endfunction

    // Drives one decode slot for one clock; starts at least 2 time units before a rising edge.
    task automatic applyStimulus(input instr_t s, input logic f);
        logic exp_stall;
        id_cur = s;
        flush  = f;
        #1;
        exp_stall = load_use(m_ex, s) && !f;
        checkOutput("stall_pcw_ifw", {stall, pc_write, if_id_write}, {exp_stall, !exp_stall, !exp_stall});
        @(posedge clk);
        if (exp_stall && m_stalls < CNT_MAX) m_stalls++;
        if (f && s.valid && m_flushes < CNT_MAX) m_flushes++;
        if (f || exp_stall || !s.valid) m_ex = '0;
        else m_ex = s;
        #1;
        checkOutput("ex_ctrl", ctrl_of(ex_obs), ctrl_of(m_ex));
        if (m_ex.valid) checkOutput("ex_data", data_of(ex_obs), data_of(m_ex));
        checkOutput("stall_count", stall_count, m_stalls);
        checkOutput("flush_count", flush_count, m_flushes);
        @(negedge clk);
    endtask

    task automatic checkResetState();
        checkOutput("rst_ctrl", {ctrl_of(ex_obs), ex_alusrc, ex_funct}, 0);
        checkOutput("rst_data", data_of(ex_obs), 0);
        checkOutput("rst_counts", {stall_count, flush_count}, 0);
        checkOutput("rst_stall", {stall, pc_write, if_id_write}, 3'b011);
    endtask

    // Short asynchronous reset pulse between edges; called right after a falling edge.
    task automatic pulseReset();
        #1 reset = 1'b0;
        #1 checkResetState();
        reset     = 1'b1;
        m_ex      = '0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    instr_t rtype, ld, add_dep, addi, ld0, use0, st, ldself;

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        id_cur    = rand_instr();
        m_ex      = '0;
        m_stalls  = 0;
        m_flushes = 0;
        #2 checkResetState();
        @(negedge clk);
        reset = 1'b1;

        rtype = rand_instr();
        rtype.valid = 1; rtype.aluop = 2'b10; rtype.regwrite = 1; rtype.rd = 5;
        rtype.memread = 0; rtype.memwrite = 0; rtype.branch = 0; rtype.alusrc = 0;
        applyStimulus(rtype, 0);
        checkOutput("rtype_valid", ex_valid, 1);
        checkOutput("rtype_aluop", ex_aluop, 2'b10);
        checkOutput("rtype_rd", ex_rd, 5);
        checkOutput("rtype_stall", stall, 0);

        ld = rand_instr();
        ld.valid = 1; ld.memread = 1; ld.memtoreg = 1; ld.regwrite = 1; ld.alusrc = 1;
        ld.memwrite = 0; ld.branch = 0; ld.aluop = 2'b00; ld.rd = 7; ld.rs1 = 2;
        add_dep = rtype;
        add_dep.rs1 = 7; add_dep.rs2 = 3; add_dep.rd = 9;

        pulseReset();
        applyStimulus(ld, 0);
        id_cur = add_dep;
        #1 checkOutput("lu_stall_pcw", {stall, pc_write}, 2'b10);
        applyStimulus(add_dep, 0);
        checkOutput("lu_bubble", ex_valid, 0);
        applyStimulus(add_dep, 0);
        checkOutput("lu_add_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd9});
        checkOutput("lu_stall_count", stall_count, 1);
        id_cur = ld;
        #1;
        // Mid-stall reset, then normal load of the decode instruction.
        applyStimulus(ld, 0);
        id_cur = add_dep;
        #1 checkOutput("pre_reset_stall", stall, 1);
        pulseReset();
        applyStimulus(add_dep, 0);
        checkOutput("post_reset_load", {ex_valid, ex_rd}, {1'b1, 5'd9});

        addi = rtype;
        addi.rs1 = 2; addi.rs2 = 7; addi.alusrc = 1; addi.memwrite = 0;
        pulseReset();
        applyStimulus(ld, 0);
        id_cur = addi;
        #1 checkOutput("addi_no_stall", stall, 0);
        applyStimulus(addi, 0);
        ld0 = ld; ld0.rd = 0;
        use0 = rtype; use0.rs1 = 0; use0.rs2 = 0;
        applyStimulus(ld0, 0);
        id_cur = use0;
        #1 checkOutput("rd0_no_stall", stall, 0);
        applyStimulus(use0, 0);

        st = ld;
        st.memread = 0; st.memwrite = 1; st.memtoreg = 0; st.regwrite = 0; st.rs1 = 2; st.rs2 = 7;
        pulseReset();
        applyStimulus(ld, 0);
        id_cur = st;
        flush  = 1'b1;
        #1 checkOutput("flush_beats_stall", stall, 0);
        applyStimulus(st, 1);
        checkOutput("flush_bubble", ex_valid, 0);
        checkOutput("flush_counts", {flush_count, stall_count}, {4'd1, 4'd0});

        ldself = ld; ldself.rs1 = 7;
        pulseReset();
        for (int i = 0; i < 44; i++) applyStimulus(ldself, 0);
        checkOutput("stall_saturate", stall_count, 15);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) pulseReset();
            applyStimulus(rand_instr(), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
